// File: rtl/reaction_ctrl.sv
// Reaction-timing sequencer: random delay countdown, reaction measurement,
// false-start / timeout detection and a running best (minimum) result.
module reaction_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss,
  input  logic [CNT_W-1:0] cnt,
  output logic             go,
  output logic             capture,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W-1:0] best,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StGo   = 2'd2;

  localparam logic [CNT_W-1:0] RcntLast   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             ss_q;
  logic             rise;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             capture_q, capture_d;
  logic             fs_q, fs_d;
  logic             to_q, to_d;

  assign rise = ss & ~ss_q;

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    result_d  = result_q;
    best_d    = best_q;
    capture_d = 1'b0;
    fs_d      = fs_q;
    to_d      = to_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          dcnt_d  = cnt;
          fs_d    = 1'b0;
          to_d    = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A press during the delay is a false start, even on the expiry cycle.
        if (rise) begin
          fs_d    = 1'b1;
          state_d = StIdle;
        end else if (dcnt_q == '0) begin
          rcnt_d  = '0;
          state_d = StGo;
        end else begin
          dcnt_d = dcnt_q - One;
        end
      end
      StGo: begin
        if (rise) begin
          result_d  = rcnt_q;
          capture_d = 1'b1;
          if (rcnt_q < best_q) best_d = rcnt_q;
          state_d = StIdle;
        end else if (rcnt_q == RcntLast) begin
          result_d = TimeoutVal;
          to_d     = 1'b1;
          state_d  = StIdle;
        end else begin
          rcnt_d = rcnt_q + One;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ss_q      <= 1'b1;  // a button held through reset release is not a press
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      result_q  <= '0;
      best_q    <= '1;
      capture_q <= 1'b0;
      fs_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_q      <= ss;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      result_q  <= result_d;
      best_q    <= best_d;
      capture_q <= capture_d;
      fs_q      <= fs_d;
      to_q      <= to_d;
    end
  end

  assign go          = (state_q == StGo);
  assign busy        = (state_q != StIdle);
  assign capture     = capture_q;
  assign result      = result_q;
  assign best        = best_q;
  assign false_start = fs_q;
  assign timeout     = to_q;

endmodule
